// File: rtl/mux_arb_pkg.sv
// Shared constants and FSM encoding for the round-robin mux arbiter.
// MAX_HOLD is accepted in the range MAX_HOLD_MIN..MAX_HOLD_MAX.
package mux_arb_pkg;

    localparam int N_REQ        = 4;
    localparam int SEL_W        = 2;
    localparam int MAX_HOLD_MIN = 1;
    localparam int MAX_HOLD_MAX = 255;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    assign any = |req;

    // Scan from the farthest offset down so the nearest set bit wins.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        idx = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
        end
    end

    assign onehot = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux with a valid/ready output and a
// per-grant beat limit; handover between grants happens without a bubble.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    input  logic              ready,
    output logic [N_REQ-1:0]  gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              valid,
    output logic [DATA_W-1:0] y
);

    localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q,   ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [N_REQ-1:0]  gnt_q,   gnt_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;

    logic              granted;
    logic              beat;
    logic              release_now;
    logic [SEL_W-1:0]  pick_ptr;
    logic              win_any;
    logic [SEL_W-1:0]  win_idx;
    logic [N_REQ-1:0]  win_onehot;

    assign granted     = (state_q == ST_GRANT);
    assign valid       = granted && req[sel_q];
    assign beat        = valid && ready;
    assign release_now = granted && (!req[sel_q] || (beat && (cnt_q == CNT_LAST)));

    // While granted the picker only matters on release, where the search
    // starts just past the current owner; in IDLE it starts at ptr.
    assign pick_ptr = granted ? (sel_q + SEL_W'(1)) : ptr_q;

    rr_pick u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .any    (win_any),
        .idx    (win_idx),
        .onehot (win_onehot)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        if (!granted) begin
            if (win_any) begin
                state_d = ST_GRANT;
                gnt_d   = win_onehot;
                sel_d   = win_idx;
                cnt_d   = '0;
            end
        end else if (release_now) begin
            ptr_d = pick_ptr;
            cnt_d = '0;
            if (win_any) begin
                gnt_d = win_onehot;
                sel_d = win_idx;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        end else if (beat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        y = '0;
        if (valid) begin
            case (sel_q)
                2'd0:    y = i0;
                2'd1:    y = i1;
                2'd2:    y = i2;
                default: y = i3;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

    assign gnt = gnt_q;
    assign sel = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: table-driven cycle vectors through a
// scoreboard queue, hand-written corner sequences, and a per-cycle monitor.
module tb_mux_rr_arbiter;

    localparam int DW   = 4;
    localparam int HOLD = 4;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ready;
        logic [3:0] exp_gnt;
        logic [1:0] exp_sel;
        logic       exp_valid;
        int         rep;
    } vec_t;

    typedef struct {
        logic [3:0]    gnt;
        logic [1:0]    sel;
        logic          chk_sel;
        logic          valid;
        logic [DW-1:0] y;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req;
    logic          ready;
    logic [DW-1:0] din [4];
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          valid;
    logic [DW-1:0] y;

    int   n_checks;
    int   n_errors;
    bit   mon_en;
    vec_t tbl[$];
    exp_t sb[$];

    mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .i0    (din[0]),
        .i1    (din[1]),
        .i2    (din[2]),
        .i3    (din[3]),
        .ready (ready),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] r, input logic rdy,
                       input logic [3:0] g, input logic [1:0] s, input logic v, input int rep);
        vec_t t;
        t.rst = rst; t.req = r; t.ready = rdy;
        t.exp_gnt = g; t.exp_sel = s; t.exp_valid = v; t.rep = rep;
        tbl.push_back(t);
    endtask

    // One cycle: drive inputs after the falling edge, queue the expectation,
    // then compare shortly after while the inputs are settled.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n = !v.rst;
        req   = v.req;
        ready = v.ready;
        for (int k = 0; k < 4; k++) din[k] = DW'($urandom_range(0, 15));
        e.gnt     = v.exp_gnt;
        e.sel     = v.exp_sel;
        e.chk_sel = v.rst || (v.exp_gnt != 4'b0);
        e.valid   = v.exp_valid;
        e.y       = v.exp_valid ? din[v.exp_sel] : '0;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        check("gnt", 32'(gnt), 32'(got.gnt));
        if (got.chk_sel) check("sel", 32'(sel), 32'(got.sel));
        check("valid", 32'(valid), 32'(got.valid));
        check("y", 32'(y), 32'(got.y));
    endtask

    task automatic step_args(input logic rst, input logic [3:0] r, input logic rdy,
                             input logic [3:0] g, input logic [1:0] s, input logic v);
        vec_t t;
        t.rst = rst; t.req = r; t.ready = rdy;
        t.exp_gnt = g; t.exp_sel = s; t.exp_valid = v; t.rep = 1;
        step(t);
    endtask

    // Per-cycle invariants: mux output, grant encoding, hold limit, fairness.
    logic [3:0] prev_gnt;
    logic [3:0] last_nz_gnt;
    int         beats;
    int         waits [4];

    always begin
        logic [DW-1:0] exp_y;
        @(negedge clk);
        #2;
        if (!rst_n || !mon_en) begin
            prev_gnt    = '0;
            last_nz_gnt = '0;
            beats       = 0;
            for (int k = 0; k < 4; k++) waits[k] = 0;
        end else begin
            exp_y = valid ? din[sel] : '0;
            check("mon_y", 32'(y), 32'(exp_y));
            check("mon_onehot", 32'($onehot0(gnt)), 32'(1));
            check("mon_gnt_sel", 32'((gnt == 4'b0) || (gnt == (4'b1 << sel))), 32'(1));
            if ((gnt != prev_gnt) || ((req & ~gnt) == 4'b0)) beats = 0;
            if (valid && ready) beats++;
            check("mon_hold_limit", 32'(beats > HOLD), 32'(0));
            if ((gnt != 4'b0) && (gnt != last_nz_gnt)) begin
                for (int k = 0; k < 4; k++) if (req[k] && !gnt[k]) waits[k]++;
            end
            for (int k = 0; k < 4; k++) begin
                if (!req[k] || gnt[k]) waits[k] = 0;
                check("mon_starve", 32'(waits[k] > 3), 32'(0));
            end
            prev_gnt = gnt;
            if (gnt != 4'b0) last_nz_gnt = gnt;
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b1;
        rst_n    = 1'b0;
        req      = '0;
        ready    = 1'b0;
        for (int k = 0; k < 4; k++) din[k] = '0;

        // Rotation under full load with reset held on 1111.
        add(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 4);
        add(0, 4'b1111, 1, 4'b0010, 2'd1, 1, 4);
        add(0, 4'b1111, 1, 4'b0100, 2'd2, 1, 4);
        add(0, 4'b1111, 1, 4'b1000, 2'd3, 1, 4);
        add(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 1);
        // Sole requester is re-granted, then withdraws into IDLE.
        add(1, 4'b0100, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b0100, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b0100, 1, 4'b0100, 2'd2, 1, 8);
        add(0, 4'b0000, 1, 4'b0100, 2'd2, 0, 1);
        add(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 2);
        // Ten-cycle stall on sel=1 freezes the beat count.
        add(1, 4'b1010, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1010, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1010, 1, 4'b0010, 2'd1, 1, 1);
        add(0, 4'b1010, 0, 4'b0010, 2'd1, 1, 10);
        add(0, 4'b1010, 1, 4'b0010, 2'd1, 1, 3);
        add(0, 4'b1010, 1, 4'b1000, 2'd3, 1, 1);
        // Requester 0 withdraws after two beats with 3 pending.
        add(1, 4'b1001, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1001, 1, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1001, 1, 4'b0001, 2'd0, 1, 2);
        add(0, 4'b1000, 1, 4'b0001, 2'd0, 0, 1);
        add(0, 4'b1001, 1, 4'b1000, 2'd3, 1, 4);
        add(0, 4'b1001, 1, 4'b0001, 2'd0, 1, 1);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) step(tbl[i]);
        end

        // Asynchronous reset between edges during a grant; ptr must return to 0.
        step_args(1, 4'b1111, 1, 4'b0000, 2'd0, 0);
        step_args(0, 4'b1111, 1, 4'b0000, 2'd0, 0);
        for (int b = 0; b < 4; b++) step_args(0, 4'b1111, 1, 4'b0001, 2'd0, 1);
        step_args(0, 4'b1111, 1, 4'b0010, 2'd1, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'(0));
        check("async_rst_sel", 32'(sel), 32'(0));
        check("async_rst_valid", 32'(valid), 32'(0));
        check("async_rst_y", 32'(y), 32'(0));
        step_args(1, 4'b0101, 1, 4'b0000, 2'd0, 0);
        step_args(0, 4'b0101, 1, 4'b0000, 2'd0, 0);
        step_args(0, 4'b0101, 1, 4'b0001, 2'd0, 1);

        // A short pulse on a non-granted request during a grant is not latched.
        step_args(1, 4'b0001, 1, 4'b0000, 2'd0, 0);
        step_args(0, 4'b0001, 1, 4'b0000, 2'd0, 0);
        step_args(0, 4'b0001, 1, 4'b0001, 2'd0, 1);
        step_args(0, 4'b0101, 0, 4'b0001, 2'd0, 1);
        step_args(0, 4'b0001, 0, 4'b0001, 2'd0, 1);
        step_args(0, 4'b0000, 1, 4'b0001, 2'd0, 0);
        step_args(0, 4'b0000, 1, 4'b0000, 2'd0, 0);

        mon_en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
